stage_multdiv: RTL and testbench
================================

STAGE_MULTDIV -- requirements
Module: stage_multdiv

Interface
REQ-001 SHALL have port: clock  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have port: insn  input  32  instruction currently in execute; opcode [31:27], rd [26:22], ALU op [6:2].
REQ-004 SHALL have port: operandA  input  32  bypassed rs value, used as multiplicand or dividend.
REQ-005 SHALL have port: operandB  input  32  bypassed rt value, used as multiplier or divisor.
REQ-006 SHALL have port: stall  output  1  freezes PC, FD and DX latches while high.
REQ-007 SHALL have port: result  output  32  product, quotient or exception code.
REQ-008 SHALL have port: result_rd  output  5  destination register for result.
REQ-009 SHALL have port: result_valid  output  1  one-cycle strobe that result/result_rd are to be latched into XM.
REQ-010 SHALL have port: write_exception  output  1  high with result_valid when the operation faulted.
REQ-011 SHALL have port, present only with MULTDIV_FLUSH_EN: flush  input  1  abort the operation in flight.

Function
REQ-012 SHALL decode mul as opcode 00000 with ALU op 00110, and div as opcode 00000 with ALU op 00111; all other insns are ignored.
REQ-013 SHALL implement states IDLE, MUL, DIV, DONE.
REQ-014 SHALL, in IDLE with a decoded mul, capture operands and rd and enter MUL, clearing a 5-bit iteration counter.
REQ-015 SHALL, in IDLE with a decoded div, capture operands and rd, then enter DIV, or enter DONE directly if operandB == 0.
REQ-016 SHALL drive stall combinationally high in IDLE when a mul/div is decoded, high throughout MUL and DIV, and low in DONE and otherwise.
REQ-017 SHALL, in MUL, perform one unsigned shift-add step per cycle on operand magnitudes (a 64-bit accumulator), and enter DONE after 32 steps (counter wrap 31->0).
REQ-018 SHALL, in DIV, perform one restoring shift-subtract step per cycle on magnitudes, and enter DONE after 32 steps.
REQ-019 SHALL apply sign on entry to DONE: product/quotient is negated when operand sign bits differ; the remainder is discarded.
REQ-020 SHALL flag mul overflow when the signed 64-bit product does not equal the sign extension of its low 32 bits.
REQ-021 SHALL flag div exception on divisor == 0.
REQ-022 SHALL, in DONE, assert result_valid for exactly one cycle and then return to IDLE.
REQ-023 SHALL, on exception, output result = 4 (mul) or 5 (div), result_rd = 30, and write_exception = 1.
REQ-024 SHALL, without exception, output result = the low 32 bits, result_rd = the captured rd, and write_exception = 0.
REQ-025 SHALL yield latency from the accepting IDLE cycle N to result_valid of N+33 for mul and for non-zero div, and N+1 for div by zero.
REQ-026 SHALL ignore insn while not in IDLE; the held DX insn is the same one and is not re-accepted in the DONE cycle.
REQ-027 SHALL accept a new mul/div in the cycle after DONE, so back-to-back operations have no extra bubble.
REQ-028 SHALL treat the most-negative case (-2^31 / -1) as an overflow exception with result 5.

Reset
REQ-029 SHALL, on reset assertion, asynchronously force state IDLE, counter 0 and all captured registers 0, with stall = 0, result = 0, result_rd = 0, result_valid = 0 and write_exception = 0.
REQ-030 SHALL, on reset mid-operation, abandon the operation with no result_valid, and resume normally on the first edge after deassertion.

Configuration
REQ-031 SHALL, with macro MULTDIV_FLUSH_EN defined, have the flush port; flush high in any state returns to IDLE on the next edge, suppresses result_valid, and drops stall the same cycle combinationally; flush takes priority over acceptance in IDLE.
REQ-032 SHALL, without MULTDIV_FLUSH_EN, omit the flush port; operations always run to completion.

Verification
REQ-033 SHALL pass: mul rd=5, A=7, B=-3 -> stall for cycles N..N+32, result_valid at N+33 with result=0xFFFFFFEB, result_rd=5, write_exception=0.
REQ-034 SHALL pass: div rd=9, A=100, B=7 -> result_valid at N+33, result=14, result_rd=9.
REQ-035 SHALL pass: div A=1, B=0 -> result_valid at N+1, result=5, result_rd=30, write_exception=1.
REQ-036 SHALL pass: mul A=0x00010000, B=0x00010000 -> result=4, result_rd=30, write_exception=1.
REQ-037 SHALL pass: reset pulsed at N+10 of a mul -> all outputs 0 immediately, no result_valid, next mul completes at its own N+33.
REQ-038 SHALL pass, with MULTDIV_FLUSH_EN: flush at N+5 of a div -> stall low that cycle, IDLE next, no result_valid.

Source files
------------

// File: rtl/stage_multdiv.sv
// Iterative signed multiply/divide execute stage: 32-cycle shift-add / restoring divide on magnitudes.
// Optional MULTDIV_FLUSH_EN adds a flush input that aborts the operation in flight.
module stage_multdiv (
  input  logic        clock,
  input  logic        reset,
`ifdef MULTDIV_FLUSH_EN
  input  logic        flush,
`endif
  input  logic [31:0] insn,
  input  logic [31:0] operandA,
  input  logic [31:0] operandB,
  output logic        stall,
  output logic [31:0] result,
  output logic [4:0]  result_rd,
  output logic        result_valid,
  output logic        write_exception
);

  localparam int unsigned W  = 32;
  localparam int unsigned AW = 64;
  localparam int unsigned CW = 5;
  localparam int unsigned RW = 5;
  localparam logic [4:0]   OP_RTYPE = 5'b00000;
  localparam logic [4:0]   ALU_MUL  = 5'b00110;
  localparam logic [4:0]   ALU_DIV  = 5'b00111;
  localparam logic [RW-1:0] EXC_RD  = RW'(30);
  localparam logic [W-1:0]  MUL_EXC = W'(4);
  localparam logic [W-1:0]  DIV_EXC = W'(5);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [AW-1:0]   r_acc;
  logic [W-1:0]    r_opd;
  logic            r_neg;
  logic [RW-1:0]   r_rd;
  logic [W-1:0]    r_result;
  logic [RW-1:0]   r_result_rd;
  logic            r_valid;
  logic            r_exc;

  logic            w_flush;
  logic            w_is_mul;
  logic            w_is_div;
  logic [W-1:0]    w_a_mag;
  logic [W-1:0]    w_b_mag;
  logic [W:0]      w_mul_sum;
  logic [AW-1:0]   w_mul_next;
  logic [AW-1:0]   w_prod;
  logic            w_mul_ovf;
  logic [AW-1:0]   w_div_shift;
  logic [W:0]      w_div_trial;
  logic [AW-1:0]   w_div_next;
  logic [W-1:0]    w_quo;
  logic            w_div_ovf;

`ifdef MULTDIV_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  assign w_is_mul = (insn[31:27] == OP_RTYPE) && (insn[6:2] == ALU_MUL);
  assign w_is_div = (insn[31:27] == OP_RTYPE) && (insn[6:2] == ALU_DIV);
  assign w_a_mag  = operandA[W-1] ? W'(-operandA) : operandA;
  assign w_b_mag  = operandB[W-1] ? W'(-operandB) : operandB;

  // Shift-add step: conditionally add multiplicand into the high half, then shift right.
  assign w_mul_sum  = {1'b0, r_acc[AW-1:W]} + (r_acc[0] ? {1'b0, r_opd} : (W+1)'(0));
  assign w_mul_next = {w_mul_sum, r_acc[W-1:1]};
  assign w_prod     = r_neg ? AW'(-w_mul_next) : w_mul_next;
  assign w_mul_ovf  = !((&w_prod[AW-1:W-1]) || !(|w_prod[AW-1:W-1]));

  // Restoring step: remainder in the high half, quotient bits shift into the low half.
  assign w_div_shift = {r_acc[AW-2:0], 1'b0};
  assign w_div_trial = {1'b0, w_div_shift[AW-1:W]} - {1'b0, r_opd};
  assign w_div_next  = w_div_trial[W] ? w_div_shift
                                      : {w_div_trial[W-1:0], w_div_shift[W-1:1], 1'b1};
  assign w_quo       = r_neg ? W'(-w_div_next[W-1:0]) : w_div_next[W-1:0];
  // Only a positive quotient of magnitude 2^31 (-2^31 / -1) is unrepresentable.
  assign w_div_ovf   = !r_neg && w_div_next[W-1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_opd       <= '0;
      r_neg       <= 1'b0;
      r_rd        <= '0;
      r_result    <= '0;
      r_result_rd <= '0;
      r_valid     <= 1'b0;
      r_exc       <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_flush) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_is_mul) begin
              r_opd   <= w_a_mag;
              r_acc   <= {W'(0), w_b_mag};
              r_neg   <= operandA[W-1] ^ operandB[W-1];
              r_rd    <= insn[26:22];
              r_cnt   <= '0;
              r_state <= S_MUL;
            end else if (w_is_div) begin
              r_opd <= w_b_mag;
              r_acc <= {W'(0), w_a_mag};
              r_neg <= operandA[W-1] ^ operandB[W-1];
              r_rd  <= insn[26:22];
              r_cnt <= '0;
              if (operandB == '0) begin
                r_result    <= DIV_EXC;
                r_result_rd <= EXC_RD;
                r_exc       <= 1'b1;
                r_valid     <= 1'b1;
                r_state     <= S_DONE;
              end else begin
                r_state <= S_DIV;
              end
            end
          end
          S_MUL: begin
            r_acc <= w_mul_next;
            r_cnt <= CW'(r_cnt + 1'b1);
            if (r_cnt == CW'(31)) begin
              r_result    <= w_mul_ovf ? MUL_EXC : w_prod[W-1:0];
              r_result_rd <= w_mul_ovf ? EXC_RD : r_rd;
              r_exc       <= w_mul_ovf;
              r_valid     <= 1'b1;
              r_state     <= S_DONE;
            end
          end
          S_DIV: begin
            r_acc <= w_div_next;
            r_cnt <= CW'(r_cnt + 1'b1);
            if (r_cnt == CW'(31)) begin
              r_result    <= w_div_ovf ? DIV_EXC : w_quo;
              r_result_rd <= w_div_ovf ? EXC_RD : r_rd;
              r_exc       <= w_div_ovf;
              r_valid     <= 1'b1;
              r_state     <= S_DONE;
            end
          end
          S_DONE: r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Stall is combinational so the pipeline freezes in the accepting cycle itself.
  assign stall = !reset && !w_flush &&
                 (((r_state == S_IDLE) && (w_is_mul || w_is_div)) ||
                  (r_state == S_MUL) || (r_state == S_DIV));

  assign result          = r_result;
  assign result_rd       = r_result_rd;
  assign result_valid    = r_valid;
  assign write_exception = r_exc;

endmodule

// File: tb/tb_stage_multdiv.sv
// Scoreboard bench for stage_multdiv: driver pushes expected results, monitor pops on result_valid.
module tb_stage_multdiv;

  logic        clock;
  logic        reset;
  logic        flush;
  logic [31:0] insn;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic        stall;
  logic [31:0] result;
  logic [4:0]  result_rd;
  logic        result_valid;
  logic        write_exception;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        exc;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  stage_multdiv dut (
    .clock(clock),
    .reset(reset),
`ifdef MULTDIV_FLUSH_EN
    .flush(flush),
`endif
    .insn(insn),
    .operandA(operandA),
    .operandB(operandB),
    .stall(stall),
    .result(result),
    .result_rd(result_rd),
    .result_valid(result_valid),
    .write_exception(write_exception)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] aluop);
    return {5'b00000, rd, 15'b0, aluop, 2'b00};
  endfunction

  localparam logic [4:0] MUL = 5'b00110;
  localparam logic [4:0] DIV = 5'b00111;

  // Monitor: every result_valid must match the oldest expectation, including its cycle.
  always @(negedge clock) begin
    if (result_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'(result_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("result_rd", 32'(result_rd), 32'(e.rd));
        chk("write_exception", 32'(write_exception), 32'(e.exc));
        chk("valid_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Drive one op at a negedge in IDLE, check stall each cycle through DONE; insn stays held.
  task automatic run_op(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic [4:0] rd, input logic exc,
                        input int lat);
    exp_t e;
    @(negedge clock);
    insn = ins; operandA = a; operandB = b;
    e.res = res; e.rd = rd; e.exc = exc; e.cyc = cyc + lat;
    sb.push_back(e);
    for (int k = 0; k <= lat; k++) begin
      if (k > 0) @(negedge clock);
      #1;
      if (k == 0 || k == lat - 1 || k == lat)
        chk($sformatf("stall_k%0d", k), 32'(stall), 32'(k < lat));
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    insn = mk(5'd5, MUL); operandA = 32'd7; operandB = 32'hFFFF_FFFD;
    repeat (2) @(negedge clock);
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_rd", 32'(result_rd), 32'd0);
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_exc", 32'(write_exception), 32'd0);
    insn = 32'd0;
    @(negedge clock);
    reset = 1'b0;

    run_op(mk(5'd5, MUL), 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 5'd5, 1'b0, 33);
    // Held insn in DONE must not be re-accepted.
    @(negedge clock); insn = 32'd0; #1;
    chk("no_reaccept_stall", 32'(stall), 32'd0);

    run_op(mk(5'd9, DIV), 32'd100, 32'd7, 32'd14, 5'd9, 1'b0, 33);
    run_op(mk(5'd3, MUL), 32'hFFFF_FFFA, 32'hFFFF_FFF9, 32'd42, 5'd3, 1'b0, 33);
    run_op(mk(5'd8, DIV), 32'd1, 32'd0, 32'd5, 5'd30, 1'b1, 1);
    run_op(mk(5'd2, MUL), 32'h0001_0000, 32'h0001_0000, 32'd4, 5'd30, 1'b1, 33);
    run_op(mk(5'd2, DIV), 32'h8000_0000, 32'hFFFF_FFFF, 32'd5, 5'd30, 1'b1, 33);
    run_op(mk(5'd4, DIV), 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 5'd4, 1'b0, 33);
    run_op(mk(5'd6, MUL), 32'h8000_0000, 32'd1, 32'h8000_0000, 5'd6, 1'b0, 33);
    run_op(mk(5'd7, DIV), 32'd7, 32'hFFFF_FF9C, 32'd0, 5'd7, 1'b0, 33);
    run_op(mk(5'd1, MUL), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 5'd1, 1'b0, 33);

    // Non-mul/div ALU op and non-zero opcode are ignored.
    @(negedge clock); insn = mk(5'd1, 5'b00000); #1;
    chk("ignore_alu_stall", 32'(stall), 32'd0);
    @(negedge clock); insn = mk(5'd1, MUL) | 32'h0800_0000; #1;
    chk("ignore_opcode_stall", 32'(stall), 32'd0);

    // Reset mid-mul: outputs clear immediately, no result, next mul runs its full latency.
    @(negedge clock);
    insn = mk(5'd11, MUL); operandA = 32'd3; operandB = 32'd4;
    repeat (10) @(negedge clock);
    reset = 1'b1; #1;
    chk("midrst_stall", 32'(stall), 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_rd", 32'(result_rd), 32'd0);
    chk("midrst_valid", 32'(result_valid), 32'd0);
    chk("midrst_exc", 32'(write_exception), 32'd0);
    @(negedge clock); reset = 1'b0; insn = 32'd0;
    run_op(mk(5'd12, MUL), 32'd3, 32'd4, 32'd12, 5'd12, 1'b0, 33);

`ifdef MULTDIV_FLUSH_EN
    @(negedge clock);
    insn = mk(5'd13, DIV); operandA = 32'd50; operandB = 32'd5;
    repeat (5) @(negedge clock);
    flush = 1'b1; insn = 32'd0; #1;
    chk("flush_stall", 32'(stall), 32'd0);
    @(negedge clock); flush = 1'b0; #1;
    chk("post_flush_stall", 32'(stall), 32'd0);
    run_op(mk(5'd14, DIV), 32'd50, 32'd5, 32'd10, 5'd14, 1'b0, 33);
`endif

    @(negedge clock); insn = 32'd0;
    repeat (40) @(negedge clock);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
